vc_wrr_arbiter: RTL

- Downstream stage of the four per-VC input FIFOs.
- Pops words from the VC FIFOs under weighted round-robin and registers the popped word.
- One cycle later, pushes the word into one of four destination FIFOs, selected by the word's destination field.
- Stalls globally on any destination FIFO almost-full/full, so no word is ever dropped.

---
 rtl/vc_wrr_arbiter_pkg.sv | 22 ++
 rtl/vc_wrr_arbiter_if.sv | 34 +++
 rtl/vc_wrr_arbiter_rr_next_sel.sv | 32 +++
 rtl/vc_wrr_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/vc_wrr_arbiter_pkg.sv
// Shared definitions for the weighted round-robin VC arbiter.
//   NUM_VC       : number of virtual channels / destination FIFOs
//   arb_state_e  : arbiter FSM state encoding
//   dst_hi/dst_lo: bit positions of the destination select inside a word
package vc_wrr_arbiter_pkg;

  localparam int unsigned NUM_VC = 4;

  typedef enum logic {
    StIdle  = 1'b0,
    StServe = 1'b1
  } arb_state_e;

  function automatic int unsigned dst_hi(int unsigned bw);
    return bw - 1;
  endfunction

  function automatic int unsigned dst_lo(int unsigned bw);
    return bw - 2;
  endfunction

endpackage

// File: rtl/vc_wrr_arbiter_if.sv
// Bus between the VC input FIFOs, the arbiter and the destination FIFOs.
//   vc_empty        : empty flag per input FIFO
//   vc_data         : read data of input FIFO i in slice [i*BW +: BW]
//   vc_rd           : read strobe per input FIFO (one-hot or zero)
//   dst_almost_full : almost-full flag per destination FIFO
//   dst_full        : full flag per destination FIFO
//   dst_wr          : write strobe per destination FIFO (one-hot or zero)
//   dst_data        : word written to the selected destination FIFO
// master = arbiter side, slave = FIFO side.
interface vc_wrr_arbiter_if
  import vc_wrr_arbiter_pkg::*;
#(
  parameter int unsigned BW = 6
) ();

  logic [NUM_VC-1:0]    vc_empty;
  logic [NUM_VC*BW-1:0] vc_data;
  logic [NUM_VC-1:0]    vc_rd;
  logic [NUM_VC-1:0]    dst_almost_full;
  logic [NUM_VC-1:0]    dst_full;
  logic [NUM_VC-1:0]    dst_wr;
  logic [BW-1:0]        dst_data;

  modport master (
    input  vc_empty, vc_data, dst_almost_full, dst_full,
    output vc_rd, dst_wr, dst_data
  );

  modport slave (
    output vc_empty, vc_data, dst_almost_full, dst_full,
    input  vc_rd, dst_wr, dst_data
  );

endinterface

// File: rtl/vc_wrr_arbiter_rr_next_sel.sv
// Round-robin search helper.
//   req  : request vector, one bit per VC
//   ptr  : current pointer
//   incl : 1 -> search starts at ptr; 0 -> search starts at ptr+1 and ends at ptr
//   sel  : first requesting index in search order (ptr when nothing requests)
module rr_next_sel
  import vc_wrr_arbiter_pkg::*;
(
  input  logic [NUM_VC-1:0] req,
  input  logic [1:0]        ptr,
  input  logic              incl,
  output logic [1:0]        sel
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    sel   = ptr;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      // 2-bit sum wraps 3 -> 0 for free
      idx = ptr + 2'(k) + {1'b0, ~incl};
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_wrr_arbiter.sv
// Weighted round-robin arbiter between four VC input FIFOs and four destination FIFOs.
// A granted word is registered and written one cycle later into the destination FIFO
// selected by its top two bits. Any destination almost-full/full stalls new grants.
//   clk      : clock
//   reset    : synchronous active-high reset
//   bus      : FIFO bus (master side)
//   grant_vc : VC currently holding the turn pointer
//   idle     : no VC has data and no word is in flight
module vc_wrr_arbiter
  import vc_wrr_arbiter_pkg::*;
#(
  parameter int unsigned BW = 6,
  parameter int unsigned W0 = 4,
  parameter int unsigned W1 = 2,
  parameter int unsigned W2 = 1,
  parameter int unsigned W3 = 1
) (
  input  logic              clk,
  input  logic              reset,
  vc_wrr_arbiter_if.master  bus,
  output logic [1:0]        grant_vc,
  output logic              idle
);

  localparam int unsigned DstHi = dst_hi(BW);
  localparam int unsigned DstLo = dst_lo(BW);
  localparam logic [3:0] Wgt [NUM_VC] = '{4'(W0), 4'(W1), 4'(W2), 4'(W3)};

  arb_state_e        state_q;
  logic [1:0]        ptr_q;
  logic [3:0]        credit_q;
  logic              v_q;
  logic [BW-1:0]     data_q;

  logic              stall;
  logic              rd_en;
  logic [BW-1:0]     rd_word;
  logic [NUM_VC-1:0] req;
  logic [1:0]        sel_at;
  logic [1:0]        sel_after;

  assign req     = ~bus.vc_empty;
  assign stall   = (|bus.dst_almost_full) | (|bus.dst_full);
  assign rd_en   = (state_q == StServe) & req[ptr_q] & ~stall;
  assign rd_word = bus.vc_data[int'(ptr_q) * BW +: BW];

  rr_next_sel u_sel_at (
    .req  (req),
    .ptr  (ptr_q),
    .incl (1'b1),
    .sel  (sel_at)
  );

  rr_next_sel u_sel_after (
    .req  (req),
    .ptr  (ptr_q),
    .incl (1'b0),
    .sel  (sel_after)
  );

  always_comb begin
    bus.vc_rd        = '0;
    bus.vc_rd[ptr_q] = rd_en;
  end

  // Write demux: the in-flight word goes out regardless of stall, which is why
  // destination almost-full thresholds must keep one slot in reserve.
  always_comb begin
    bus.dst_wr = '0;
    if (v_q) begin
      bus.dst_wr[data_q[DstHi:DstLo]] = 1'b1;
    end
  end

  assign bus.dst_data = data_q;
  assign grant_vc     = ptr_q;
  assign idle         = (state_q == StIdle) & ~v_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      credit_q <= '0;
      v_q      <= 1'b0;
      data_q   <= '0;
    end else begin
      v_q <= rd_en;
      if (rd_en) begin
        data_q <= rd_word;
      end
      if (!stall) begin
        case (state_q)
          StIdle: begin
            if (|req) begin
              state_q  <= StServe;
              ptr_q    <= sel_at;
              credit_q <= '0;
            end
          end
          StServe: begin
            if (~|req) begin
              state_q <= StIdle;
            end else if (rd_en) begin
              if (credit_q == Wgt[ptr_q] - 4'd1) begin
                credit_q <= '0;
                ptr_q    <= sel_after;
              end else begin
                credit_q <= credit_q + 4'd1;
              end
            end else begin
              // Current VC ran dry: hand the turn on, costing one bubble cycle
              credit_q <= '0;
              ptr_q    <= sel_after;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
